// File: rtl/button_debounce_if.sv
// Push-button conditioning bundle: raw pad input plus the debounced
// level, strobes, toggle and press counter handed to neighbouring UI logic.
interface button_debounce_if #(
  parameter int CNT_W = 8
);
  logic             btn_raw;
  logic             btn_level;
  logic             press_pulse;
  logic             release_pulse;
  logic             toggle;
  logic [CNT_W-1:0] press_count;

  modport master (
    output btn_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  toggle,
    input  press_count
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output toggle,
    output press_count
  );
endinterface

// File: rtl/button_debounce.sv
// Push-button debouncer: 2-flop synchroniser, stability-window FSM and
// registered level / press-release strobes / toggle / press counter.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned ACTIVE_LOW      = 0,
  parameter int          CNT_W           = 8
) (
  input logic             clk,
  input logic             rst,
  button_debounce_if.slave bus
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic INVERT = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    ARM_HI    = 2'd1,
    STABLE_HI = 2'd2,
    ARM_LO    = 2'd3
  } state_t;

  logic btn_in;
  logic s1, s2;

  state_t           state_q, state_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             toggle_q, toggle_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign btn_in = bus.btn_raw ^ INVERT;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= STABLE_LO;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
      count_q   <= count_d;
    end
  end

  // A bounce during ARM drops straight back to the opposite STABLE state,
  // so the stability count always restarts from zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    toggle_d  = toggle_q;
    count_d   = count_q;
    case (state_q)
      STABLE_LO: begin
        if (s2) begin
          state_d = ARM_HI;
          cnt_d   = '0;
        end
      end
      ARM_HI: begin
        if (!s2) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d  = STABLE_HI;
          cnt_d    = '0;
          level_d  = 1'b1;
          press_d  = 1'b1;
          toggle_d = ~toggle_q;
          count_d  = count_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      STABLE_HI: begin
        if (!s2) begin
          state_d = ARM_LO;
          cnt_d   = '0;
        end
      end
      ARM_LO: begin
        if (s2) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d   = STABLE_LO;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.toggle        = toggle_q;
  assign bus.press_count   = count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with a 4-cycle window: active-high
// instance a for most scenarios, active-low instance b for the inverted pad.
module tb_button_debounce;
  localparam int unsigned DC = 4;
  localparam int          CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  button_debounce_if #(.CNT_W(CW)) bus_a ();
  button_debounce_if #(.CNT_W(CW)) bus_b ();

  button_debounce #(.DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(0), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int vectors    = 0;
  int miscompares = 0;
  int press_seen = 0;
  int rel_seen   = 0;
  int both_seen  = 0;
  int level_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus_a.press_pulse === 1'b1) press_seen++;
    if (bus_a.release_pulse === 1'b1) rel_seen++;
    if (bus_a.press_pulse === 1'b1 && bus_a.release_pulse === 1'b1) both_seen++;
    if (bus_a.btn_level === 1'b1) level_seen++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_seen();
    press_seen = 0;
    rel_seen   = 0;
    level_seen = 0;
  endtask

  initial begin
    // 1. reset, then idle
    rst = 1'b1;
    bus_a.btn_raw = 1'b0;
    bus_b.btn_raw = 1'b1;
    steps(2);
    chk("rst_level",   32'(bus_a.btn_level), 32'd0);
    chk("rst_press",   32'(bus_a.press_pulse), 32'd0);
    chk("rst_release", 32'(bus_a.release_pulse), 32'd0);
    chk("rst_toggle",  32'(bus_a.toggle), 32'd0);
    chk("rst_count",   32'(bus_a.press_count), 32'd0);
    chk("rst_b_level", 32'(bus_b.btn_level), 32'd0);
    rst = 1'b0;
    clear_seen();
    steps(20);
    chk("idle_strobes", 32'(press_seen + rel_seen), 32'd0);
    chk("idle_level",   32'(bus_a.btn_level), 32'd0);

    // 2. clean press: level rises on the 7th edge after the step
    bus_a.btn_raw = 1'b1;
    clear_seen();
    steps(6);
    chk("press_e6_level", 32'(bus_a.btn_level), 32'd0);
    step();
    chk("press_e7_level",  32'(bus_a.btn_level), 32'd1);
    chk("press_e7_pulse",  32'(bus_a.press_pulse), 32'd1);
    chk("press_e7_toggle", 32'(bus_a.toggle), 32'd1);
    chk("press_e7_count",  32'(bus_a.press_count), 32'd1);
    step();
    chk("press_e8_pulse", 32'(bus_a.press_pulse), 32'd0);
    steps(12);
    chk("press_hold_strobes", 32'(press_seen), 32'd1);
    chk("press_hold_level",   32'(bus_a.btn_level), 32'd1);
    bus_a.btn_raw = 1'b0;
    clear_seen();
    steps(20);
    chk("clean_rel_level",  32'(bus_a.btn_level), 32'd0);
    chk("clean_rel_pulses", 32'(rel_seen), 32'd1);

    // 3a. 4-edge glitch is rejected
    clear_seen();
    bus_a.btn_raw = 1'b1;
    steps(4);
    bus_a.btn_raw = 1'b0;
    steps(20);
    chk("glitch4_level_seen", 32'(level_seen), 32'd0);
    chk("glitch4_strobes",    32'(press_seen + rel_seen), 32'd0);
    chk("glitch4_count",      32'(bus_a.press_count), 32'd1);

    // 3b. 5-edge pulse is accepted
    clear_seen();
    bus_a.btn_raw = 1'b1;
    steps(5);
    bus_a.btn_raw = 1'b0;
    steps(20);
    chk("pulse5_press",  32'(press_seen), 32'd1);
    chk("pulse5_window", 32'(level_seen > 0), 32'd1);
    chk("pulse5_count",  32'(bus_a.press_count), 32'd2);
    chk("pulse5_toggle", 32'(bus_a.toggle), 32'd0);

    // 4. release with bounce 0,1,0,0,1 then 0 held
    bus_a.btn_raw = 1'b1;
    steps(20);
    chk("bounce_pre_count", 32'(bus_a.press_count), 32'd3);
    clear_seen();
    bus_a.btn_raw = 1'b0; step();
    bus_a.btn_raw = 1'b1; step();
    bus_a.btn_raw = 1'b0; step();
    bus_a.btn_raw = 1'b0; step();
    bus_a.btn_raw = 1'b1; step();
    bus_a.btn_raw = 1'b0;
    steps(6);
    chk("bounce_e6_level", 32'(bus_a.btn_level), 32'd1);
    chk("bounce_e6_rel",   32'(rel_seen), 32'd0);
    step();
    chk("bounce_e7_level", 32'(bus_a.btn_level), 32'd0);
    chk("bounce_e7_pulse", 32'(bus_a.release_pulse), 32'd1);
    steps(13);
    chk("bounce_rel_total", 32'(rel_seen), 32'd1);
    chk("bounce_toggle",    32'(bus_a.toggle), 32'd1);
    chk("bounce_count",     32'(bus_a.press_count), 32'd3);

    // 5. wrap after 256 presses from reset
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    clear_seen();
    for (int i = 0; i < 256; i++) begin
      bus_a.btn_raw = 1'b1;
      steps(8);
      bus_a.btn_raw = 1'b0;
      steps(8);
      if (i == 254) chk("wrap_255", 32'(bus_a.press_count), 32'd255);
    end
    chk("wrap_count",   32'(bus_a.press_count), 32'd0);
    chk("wrap_toggle",  32'(bus_a.toggle), 32'd0);
    chk("wrap_presses", 32'(press_seen), 32'd256);

    // 6. reset two edges after entering ARM_HI (ARM entered on edge 3)
    bus_a.btn_raw = 1'b1;
    steps(4);
    rst = 1'b1;
    step();
    chk("armrst_level", 32'(bus_a.btn_level), 32'd0);
    chk("armrst_count", 32'(bus_a.press_count), 32'd0);
    rst = 1'b0;
    steps(6);
    chk("armrst_e6_level", 32'(bus_a.btn_level), 32'd0);
    step();
    chk("armrst_e7_level", 32'(bus_a.btn_level), 32'd1);
    chk("armrst_e7_count", 32'(bus_a.press_count), 32'd1);

    // 7. active-low instance, pad steps 1 -> 0
    chk("al_idle_level", 32'(bus_b.btn_level), 32'd0);
    bus_b.btn_raw = 1'b0;
    steps(6);
    chk("al_e6_level", 32'(bus_b.btn_level), 32'd0);
    step();
    chk("al_e7_level",  32'(bus_b.btn_level), 32'd1);
    chk("al_e7_pulse",  32'(bus_b.press_pulse), 32'd1);
    chk("al_e7_toggle", 32'(bus_b.toggle), 32'd1);
    chk("al_e7_count",  32'(bus_b.press_count), 32'd1);
    step();
    chk("al_e8_pulse", 32'(bus_b.press_pulse), 32'd0);

    chk("strobes_exclusive", 32'(both_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
